// File: rtl/pipeline_id_hz.sv
// pipeline_id_hz: IF->ID decode stage with register file, load-use hazard
// detection and an ID/EX output register with valid/ready handshaking.
// Optional feature: define ID_WB_BYPASS_EN for write-through register reads.
// Sub-modules maindec and sign_zero_ext are kept in this file.

// maindec: opcode/funct to control word
// {regwrite, memtoreg, memwrite, branch, alusrc, regdst, jump, link, nez,
//  jumptoreg, shiftl16, aluop[1:0]}
module maindec (
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    output logic [12:0] ctrl,
    output logic        zeroext
);
    localparam int unsigned RW = 12, MR = 11, MW = 10, BR = 9, AS = 8, RD = 7;
    localparam int unsigned JP = 6, LK = 5, NZ = 4, JR = 3, SL = 2;

    // Combinational decode table; unknown opcodes decode to all-zero (nop)
    always_comb begin
        ctrl    = '0;
        zeroext = 1'b0;
        case (op)
            6'b000000: begin
                if (funct == 6'b001000) begin
                    ctrl[JR] = 1'b1;
                end else begin
                    ctrl[RW]  = 1'b1;
                    ctrl[RD]  = 1'b1;
                    ctrl[1:0] = 2'b10;
                end
            end
            6'b100011: begin ctrl[RW] = 1'b1; ctrl[MR] = 1'b1; ctrl[AS] = 1'b1; end
            6'b101011: begin ctrl[MW] = 1'b1; ctrl[AS] = 1'b1; end
            6'b000100: begin ctrl[BR] = 1'b1; ctrl[1:0] = 2'b01; end
            6'b000101: begin ctrl[BR] = 1'b1; ctrl[NZ] = 1'b1; ctrl[1:0] = 2'b01; end
            6'b001000: begin ctrl[RW] = 1'b1; ctrl[AS] = 1'b1; end
            6'b001100,
            6'b001101: begin
                ctrl[RW]  = 1'b1;
                ctrl[AS]  = 1'b1;
                ctrl[1:0] = 2'b11;
                zeroext   = 1'b1;
            end
            6'b001111: begin ctrl[RW] = 1'b1; ctrl[AS] = 1'b1; ctrl[SL] = 1'b1; end
            6'b000010: begin ctrl[JP] = 1'b1; end
            6'b000011: begin ctrl[RW] = 1'b1; ctrl[JP] = 1'b1; ctrl[LK] = 1'b1; end
            default: ;
        endcase
    end
endmodule

// sign_zero_ext: widen a 16-bit immediate to DW bits
module sign_zero_ext #(
    parameter int unsigned DW = 32
) (
    input  logic [15:0]   imm,
    input  logic          zeroext,
    output logic [DW-1:0] ext
);
    // Zero-extend for logical immediates, sign-extend otherwise
    always_comb begin
        if (zeroext) ext = DW'(imm);
        else         ext = DW'($signed(imm));
    end
endmodule

module pipeline_id_hz #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   pc,
    input  logic [31:0]   instr,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_reg,
    input  logic [DW-1:0] wb_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [12:0]   out_ctrl,
    output logic [31:0]   out_pc,
    output logic [AW-1:0] out_rs,
    output logic [AW-1:0] out_rt,
    output logic [AW-1:0] out_rd,
    output logic [5:0]    out_funct,
    output logic [DW-1:0] out_imm,
    output logic [DW-1:0] out_rdata_a,
    output logic [DW-1:0] out_rdata_b,
    output logic [CW-1:0] stall_cnt
);
    localparam int unsigned NREG = 1 << AW;

    logic [DW-1:0] rf [NREG];
    logic [AW-1:0] rs, rt, rd;
    logic [12:0]   dec_ctrl;
    logic          dec_zext;
    logic [DW-1:0] dec_imm;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          hazard, capture;

    assign rs = AW'(instr[25:21]);
    assign rt = AW'(instr[20:16]);
    assign rd = AW'(instr[15:11]);

    maindec u_maindec (
        .op      (instr[31:26]),
        .funct   (instr[5:0]),
        .ctrl    (dec_ctrl),
        .zeroext (dec_zext)
    );

    sign_zero_ext #(.DW(DW)) u_ext (
        .imm     (instr[15:0]),
        .zeroext (dec_zext),
        .ext     (dec_imm)
    );

    // Register file reads; register 0 always reads as zero
    always_comb begin
`ifdef ID_WB_BYPASS_EN
        rdata_a = (rs == '0) ? '0 : ((wb_en && wb_reg == rs) ? wb_data : rf[rs]);
        rdata_b = (rt == '0) ? '0 : ((wb_en && wb_reg == rt) ? wb_data : rf[rt]);
`else
        rdata_a = (rs == '0) ? '0 : rf[rs];
        rdata_b = (rt == '0) ? '0 : rf[rt];
`endif
    end

    // Load-use: a load in the ID/EX slot writing a register the incoming
    // instruction reads must wait one cycle
    assign hazard   = in_valid & out_valid & out_ctrl[11] & out_ctrl[12]
                    & (out_rt != '0) & ((out_rt == rs) | (out_rt == rt));
    assign in_ready = reset & (~out_valid | out_ready) & ~hazard & ~flush;
    assign capture  = in_valid & in_ready;

    // Register file writes from WB; register 0 is never written
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREG; i++) rf[AW'(i)] <= '0;
        end else if (wb_en && wb_reg != '0) begin
            rf[wb_reg] <= wb_data;
        end
    end

    // ID/EX valid: flush wins, then capture, then drain to a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         out_valid <= 1'b0;
        else if (flush)     out_valid <= 1'b0;
        else if (capture)   out_valid <= 1'b1;
        else if (out_ready) out_valid <= 1'b0;
    end

    // ID/EX payload loads only on capture and holds otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_ctrl    <= '0;
            out_pc      <= '0;
            out_rs      <= '0;
            out_rt      <= '0;
            out_rd      <= '0;
            out_funct   <= '0;
            out_imm     <= '0;
            out_rdata_a <= '0;
            out_rdata_b <= '0;
        end else if (capture) begin
            out_ctrl    <= dec_ctrl;
            out_pc      <= pc;
            out_rs      <= rs;
            out_rt      <= rt;
            out_rd      <= rd;
            out_funct   <= instr[5:0];
            out_imm     <= dec_imm;
            out_rdata_a <= rdata_a;
            out_rdata_b <= rdata_b;
        end
    end

    // Saturating count of hazard-stall cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                        stall_cnt <= '0;
        else if (hazard && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_pipeline_id_hz.sv
// Self-checking bench for pipeline_id_hz with a cycle-level reference model.
module tb_pipeline_id_hz;
    localparam int unsigned SMAX = 15;   // stall counter ceiling for CW = 4

    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_ORI = 6'h0d;
    localparam logic [5:0] F_ADD = 6'h20, F_OR = 6'h25, F_JR = 6'h08;
`ifdef ID_WB_BYPASS_EN
    localparam logic [31:0] EXP_COLL = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] EXP_COLL = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, out_ready, wb_en;
    logic        in_ready, out_valid;
    logic [31:0] pc, instr, wb_data;
    logic [4:0]  wb_reg;
    logic [12:0] out_ctrl;
    logic [31:0] out_pc, out_imm, out_rdata_a, out_rdata_b;
    logic [4:0]  out_rs, out_rt, out_rd;
    logic [5:0]  out_funct;
    logic [3:0]  stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic        m_valid;
    logic [12:0] m_ctrl;
    logic [31:0] m_pc, m_imm, m_ra, m_rb;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [5:0]  m_funct;
    int unsigned m_stall;
    logic [31:0] regs [32];

    pipeline_id_hz #(.DW(32), .AW(5), .CW(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .instr(instr), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_pc(out_pc), .out_rs(out_rs), .out_rt(out_rt),
        .out_rd(out_rd), .out_funct(out_funct), .out_imm(out_imm),
        .out_rdata_a(out_rdata_a), .out_rdata_b(out_rdata_b), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_ins(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [5:0] f);
        return {OP_R, s, t, d, 5'd0, f};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    // Control word per instruction class, bit order regwrite..aluop
    function automatic logic [12:0] ref_ctrl(input logic [31:0] w);
        case (w[31:26])
            6'h00:        return (w[5:0] == F_JR) ? 13'h0008 : 13'h1082;
            6'h23:        return 13'h1900;
            6'h2b:        return 13'h0500;
            6'h04:        return 13'h0201;
            6'h05:        return 13'h0211;
            6'h08:        return 13'h1100;
            6'h0c, 6'h0d: return 13'h1103;
            6'h0f:        return 13'h1104;
            6'h02:        return 13'h0040;
            6'h03:        return 13'h1060;
            default:      return 13'h0000;
        endcase
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        logic [15:0] im;
        im = w[15:0];
        if (w[31:26] == 6'h0c || w[31:26] == 6'h0d) return {16'h0000, im};
        return {{16{im[15]}}, im};
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
        if (wb_en && wb_reg == a) return wb_data;
`endif
        return regs[a];
    endfunction

    function automatic logic model_hazard();
        logic is_load;
        is_load = m_ctrl[12] && m_ctrl[11];
        return in_valid && m_valid && is_load && m_rt != 5'd0 &&
               (m_rt == instr[25:21] || m_rt == instr[20:16]);
    endfunction

    function automatic logic model_ready();
        return reset && (!m_valid || out_ready) && !model_hazard() && !flush;
    endfunction

    function automatic logic [161:0] model_payload();
        return {m_ctrl, m_pc, m_rs, m_rt, m_rd, m_funct, m_imm, m_ra, m_rb};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] a, b, d;
        a = 5'($urandom_range(0, 3));
        b = 5'($urandom_range(0, 3));
        d = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 7))
            0:       return i_ins(OP_LW, a, 5'($urandom_range(1, 3)), 16'($urandom));
            1:       return r_ins(a, b, d, F_ADD);
            2:       return i_ins(OP_ADDI, a, b, 16'($urandom));
            3:       return i_ins(OP_ORI, a, b, 16'($urandom));
            4:       return i_ins(OP_SW, a, b, 16'($urandom));
            5:       return i_ins(OP_BEQ, a, b, 16'($urandom));
            6:       return r_ins(a, 5'd0, 5'd0, F_JR);
            default: return $urandom;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_ctrl = '0; m_pc = '0; m_imm = '0; m_ra = '0; m_rb = '0;
        m_rs = '0; m_rt = '0; m_rd = '0; m_funct = '0; m_stall = 0;
        for (int i = 0; i < 32; i++) regs[i] = '0;
    endtask

    // Advance one clock, updating the model from the inputs held before the edge
    task automatic step();
        logic hz, cap;
        logic [31:0] ra, rb;
        hz  = model_hazard();
        cap = in_valid && model_ready();
        ra  = ref_read(instr[25:21]);
        rb  = ref_read(instr[20:16]);
        @(posedge clk);
        if (reset) begin
            if (hz && m_stall < SMAX) m_stall++;
            if (flush) m_valid = 1'b0;
            else if (cap) begin
                m_valid = 1'b1;       m_ctrl = ref_ctrl(instr); m_pc = pc;
                m_rs = instr[25:21];  m_rt = instr[20:16];      m_rd = instr[15:11];
                m_funct = instr[5:0]; m_imm = ref_imm(instr);
                m_ra = ra;            m_rb = rb;
            end else if (out_ready) m_valid = 1'b0;
            if (wb_en && wb_reg != 5'd0) regs[wb_reg] = wb_data;
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; flush = 0; out_ready = 1; wb_en = 0; wb_reg = 0; wb_data = 0;
        pc = 0; instr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        model_reset();
        step();
        step();
        reset = 1;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        model_reset();
        in_valid = 1; instr = r_ins(5'd1, 5'd2, 5'd3, F_ADD);
        step();
        step();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if ({out_ctrl, out_pc, out_rs, out_rt, out_rd, out_funct, out_imm, out_rdata_a, out_rdata_b} !== 162'd0) begin
            n_err++; $display("FAIL rst_payload: got nonzero payload want 0"); end
        n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL rst_stall: got %0d want 0", stall_cnt); end
        in_valid = 0;
        reset = 1;
        #1;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_basic();
        do_reset();
        wb_en = 1; wb_reg = 5; wb_data = 32'h0000_1234;
        step();
        wb_en = 0; in_valid = 1; pc = 32'h100; instr = r_ins(5'd5, 5'd0, 5'd3, F_ADD);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b want 1", in_ready); end
        step();
        in_valid = 0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_rdata_a !== 32'h1234) begin n_err++; $display("FAIL basic_rdata_a: got %h want 00001234", out_rdata_a); end
        n_cmp++; if (out_ctrl[12] !== 1'b1) begin n_err++; $display("FAIL basic_regwrite: got %b want 1", out_ctrl[12]); end
        n_cmp++; if (out_rd !== 5'd3) begin n_err++; $display("FAIL basic_rd: got %0d want 3", out_rd); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_bubble: got %b want 0", out_valid); end
        n_cmp++; if (out_pc !== 32'h100) begin n_err++; $display("FAIL basic_hold_pc: got %h want 00000100", out_pc); end
    endtask

    task automatic test_load_use();
        do_reset();
        in_valid = 1; pc = 32'h200; instr = i_ins(OP_LW, 5'd1, 5'd4, 16'h0000);
        step();
        pc = 32'h204; instr = r_ins(5'd4, 5'd4, 5'd2, F_ADD);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL lu_stall_ready: got %b want 0", in_ready); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble: got %b want 0", out_valid); end
        n_cmp++; if (out_pc !== 32'h200) begin n_err++; $display("FAIL lu_hold_pc: got %h want 00000200", out_pc); end
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL lu_release_ready: got %b want 1", in_ready); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h204) begin n_err++;
            $display("FAIL lu_capture: got valid=%b pc=%h want valid=1 pc=00000204", out_valid, out_pc); end
        n_cmp++; if (out_ctrl !== 13'h1082) begin n_err++; $display("FAIL lu_ctrl: got %h want 1082", out_ctrl); end
        n_cmp++; if (stall_cnt !== 4'd1) begin n_err++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); end
    endtask

    task automatic test_backpressure();
        in_valid = 1; out_ready = 1; pc = 32'h300; instr = i_ins(OP_ADDI, 5'd1, 5'd2, 16'h0010);
        step();
        out_ready = 0; pc = 32'h304; instr = i_ins(OP_ADDI, 5'd2, 5'd3, 16'hFFFB);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
            step();
            n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h300 || out_imm !== 32'h10) begin n_err++;
                $display("FAIL bp_hold[%0d]: got valid=%b pc=%h imm=%h want 1/00000300/00000010", i, out_valid, out_pc, out_imm); end
        end
        out_ready = 1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        step();
        in_valid = 0;
        n_cmp++; if (out_pc !== 32'h304 || out_imm !== 32'hFFFF_FFFB) begin n_err++;
            $display("FAIL bp_next: got pc=%h imm=%h want 00000304/fffffffb", out_pc, out_imm); end
    endtask

    task automatic test_flush();
        in_valid = 1; out_ready = 1; pc = 32'h304; instr = i_ins(OP_ADDI, 5'd1, 5'd1, 16'h0001);
        step();
        flush = 1; pc = 32'h400; instr = i_ins(OP_ADDI, 5'd0, 5'd9, 16'h0007);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        flush = 0; in_valid = 0;
        step();
        n_cmp++; if (out_valid !== 1'b0 || out_pc === 32'h400) begin n_err++;
            $display("FAIL flush_dropped: got valid=%b pc=%h want valid=0 pc!=00000400", out_valid, out_pc); end
    endtask

    task automatic test_wb_collision();
        do_reset();
        wb_en = 1; wb_reg = 7; wb_data = 32'hDEAD_BEEF;
        in_valid = 1; pc = 32'h500; instr = r_ins(5'd7, 5'd0, 5'd1, F_OR);
        step();
        n_cmp++; if (out_rdata_a !== EXP_COLL) begin n_err++; $display("FAIL coll_rdata_a: got %h want %h", out_rdata_a, EXP_COLL); end
        wb_reg = 0; wb_data = 32'hFFFF_FFFF;
        pc = 32'h504; instr = r_ins(5'd0, 5'd7, 5'd1, F_OR);
        step();
        wb_en = 0;
        n_cmp++; if (out_rdata_b !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL coll_next_cycle: got %h want deadbeef", out_rdata_b); end
        pc = 32'h508; instr = r_ins(5'd0, 5'd0, 5'd1, F_OR);
        step();
        in_valid = 0;
        n_cmp++; if (out_rdata_a !== 32'h0) begin n_err++; $display("FAIL r0_write_ignored: got %h want 00000000", out_rdata_a); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        out_ready = 0; in_valid = 1; pc = 32'h600; instr = i_ins(OP_LW, 5'd1, 5'd4, 16'h0004);
        step();
        pc = 32'h604; instr = r_ins(5'd4, 5'd4, 5'd2, F_ADD);
        step();
        step();
        n_cmp++; if (stall_cnt !== 4'd2) begin n_err++; $display("FAIL ms_stall_before: got %0d want 2", stall_cnt); end
        #2;
        reset = 0;
        model_reset();
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || stall_cnt !== 4'd0) begin n_err++;
            $display("FAIL ms_async_clear: got valid=%b ready=%b stall=%0d want 0/0/0", out_valid, in_ready, stall_cnt); end
        n_cmp++; if ({out_ctrl, out_pc, out_imm, out_rdata_a, out_rdata_b} !== 141'd0) begin n_err++;
            $display("FAIL ms_payload: got pc=%h ctrl=%h want 0", out_pc, out_ctrl); end
        #2;
        reset = 1; in_valid = 0; out_ready = 1;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ms_discarded: got %b want 0", out_valid); end
    endtask

    task automatic test_stall_saturation();
        do_reset();
        out_ready = 0; in_valid = 1; pc = 32'h700; instr = i_ins(OP_LW, 5'd0, 5'd6, 16'h0000);
        step();
        instr = r_ins(5'd6, 5'd0, 5'd1, F_ADD);
        for (int i = 0; i < 20; i++) step();
        n_cmp++; if (stall_cnt !== 4'hF) begin n_err++; $display("FAIL stall_saturate: got %0d want 15", stall_cnt); end
        in_valid = 0; out_ready = 1;
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            wb_en     = 1'($urandom_range(0, 1));
            wb_reg    = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            pc        = $urandom;
            instr     = rand_instr();
            #1;
            n_cmp++; if (in_ready !== model_ready()) begin n_err++;
                $display("FAIL rnd_ready[%0d]: got %b want %b", i, in_ready, model_ready()); end
            step();
            n_cmp++; if (out_valid !== m_valid) begin n_err++;
                $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, m_valid); end
            n_cmp++; if ({out_ctrl, out_pc, out_rs, out_rt, out_rd, out_funct, out_imm, out_rdata_a, out_rdata_b} !== model_payload()) begin
                n_err++; $display("FAIL rnd_payload[%0d]: got %h want %h", i,
                    {out_ctrl, out_pc, out_rs, out_rt, out_rd, out_funct, out_imm, out_rdata_a, out_rdata_b}, model_payload()); end
            n_cmp++; if (stall_cnt !== 4'(m_stall)) begin n_err++;
                $display("FAIL rnd_stall[%0d]: got %0d want %0d", i, stall_cnt, m_stall); end
        end
        idle_inputs();
        step();
    endtask

    initial begin
        reset = 0;
        idle_inputs();
        model_reset();
        test_reset();
        test_basic();
        test_load_use();
        test_backpressure();
        test_flush();
        test_wb_collision();
        test_reset_mid_stall();
        test_stall_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/pipeline_id_hz.md
PIPELINE_ID_HZ -- requirements
Module: pipeline_id_hz

Interface
REQ-001 SHALL have parameter DW, default 32, register-file data width (DW >= 16).
REQ-002 SHALL have parameter AW, default 5, register address width; the register file holds 2^AW entries.
REQ-003 SHALL have parameter CW, default 16, stall-counter width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-006 in_valid  in  1  / in_ready  out  1: IF->ID handshake; an instruction is captured on a cycle with in_valid & in_ready.
REQ-007 pc  in  32  / instr  in  32: fetched PC and instruction word.
REQ-008 wb_en  in  1 / wb_reg  in  AW / wb_data  in  DW: writeback port from WB.
REQ-009 flush  in  1  synchronous kill of the ID/EX register and the incoming instruction.
REQ-010 out_valid  out  1  / out_ready  in  1: ID->EX handshake.
REQ-011 out_ctrl  out  13  {regwrite, memtoreg, memwrite, branch, alusrc, regdst, jump, link, nez, jumptoreg, shiftl16, aluop[1:0]}, MSB first.
REQ-012 out_pc  out  32 / out_rs, out_rt, out_rd  out  AW / out_funct  out  6 / out_imm  out  DW / out_rdata_a, out_rdata_b  out  DW: registered decode results.
REQ-013 stall_cnt  out  CW  saturating count of hazard-stall cycles.

Function
REQ-014 Decode SHALL use the team maindec and sign_zero_ext; imm[15:0] is sign- or zero-extended to DW.
REQ-015 rs = instr[25:21], rt = instr[20:16], rd = instr[15:11], each truncated or zero-extended to AW.
REQ-016 Register file: synchronous write on wb_en; writes to register 0 are ignored; reads of register 0 return 0; reads are combinational.
REQ-017 hazard = in_valid & out_valid & ctrl.memtoreg & ctrl.regwrite & out_rt != 0 & (out_rt == rs | out_rt == rt).
REQ-018 in_ready = (~out_valid | out_ready) & ~hazard & ~flush.
REQ-019 On capture, all out_* fields SHALL load decode results and out_valid SHALL be 1 the next cycle (latency 1).
REQ-020 When out_valid & out_ready and there is no capture, out_valid SHALL become 0 (bubble); payload fields hold their values.
REQ-021 When hazard & out_ready, exactly one bubble SHALL be inserted; the stalled instruction is captured on the following cycle.
REQ-022 When out_valid & ~out_ready, all out_* fields SHALL hold.
REQ-023 flush SHALL have priority over capture: out_valid becomes 0 next cycle and the incoming instruction is dropped.
REQ-024 stall_cnt SHALL increment on each cycle with hazard = 1 and saturate at 2^CW-1.
REQ-025 A simultaneous WB write and read of the same register SHALL follow REQ-033/034.

Reset
REQ-026 While reset = 0: out_valid, out_ctrl, out_pc, out_rs, out_rt, out_rd, out_funct, out_imm, out_rdata_a, out_rdata_b, stall_cnt and all register-file entries SHALL be 0.
REQ-027 in_ready SHALL be 0 while reset = 0.
REQ-028 Reset asserted mid-stall SHALL discard the held instruction and clear the hazard.
REQ-029 After reset deasserts, out_valid SHALL be 0 until the first capture.

Configuration
REQ-030 The macro ID_WB_BYPASS_EN SHALL select write-through reads.
REQ-031 With ID_WB_BYPASS_EN defined: if wb_en, wb_reg != 0 and wb_reg equals the read address, the read SHALL return wb_data in the same cycle.
REQ-032 Without ID_WB_BYPASS_EN: the read SHALL return the pre-write array value; the new value is visible from the next cycle.
REQ-033 (bypass) The captured out_rdata_* value SHALL equal wb_data on a same-cycle collision.
REQ-034 (no bypass) The captured out_rdata_* value SHALL equal the old contents on a same-cycle collision.

Verification
REQ-035 Reset, then write r5 = 0x0000_1234 via WB, then issue add $3,$5,$0 with out_ready = 1 -> one cycle later out_valid = 1, out_rdata_a = 0x1234, out_ctrl.regwrite = 1.
REQ-036 Issue lw $4,0($1), then add $2,$4,$4 with out_ready = 1 -> in_ready = 0 for 1 cycle, 1 bubble, add captured next cycle, stall_cnt = 1.
REQ-037 Hold out_ready = 0 for 3 cycles with a valid instruction held -> in_ready = 0 and out_* stable; on release, the next instruction is captured.
REQ-038 Assert flush in the same cycle as in_valid with addi -> out_valid = 0 next cycle; addi is not captured.
REQ-039 Write r7 = 0xDEAD_BEEF by WB in the same cycle as capture of or $1,$7,$0 -> out_rdata_a = 0xDEADBEEF with ID_WB_BYPASS_EN, old value (0) without it.
REQ-040 Drive reset low mid-stall -> all outputs 0 immediately; stall_cnt = 0.
